// File: rtl/srio_type9_pack_mux.sv
// N-channel SRIO Type 9 packetiser: round-robin grant per packet, header beat then payload
// from the granted channel's skid buffer, with byte-accurate TKEEP and status counters.
module srio_type9_pack_mux #(
   parameter int         NUM_CH = 2,
   parameter logic [1:0] PRIO   = 2'b00,
   parameter logic       CRF    = 1'b0,
   parameter int         CNT_W  = 16
) (
   input  logic                   AXIS_ACLK,
   input  logic                   AXIS_ARESET,
   input  logic [NUM_CH*64-1:0]   S_AXIS_TDATA,
   input  logic [NUM_CH-1:0]      S_AXIS_TVALID,
   input  logic [NUM_CH-1:0]      S_AXIS_TLAST,
   output logic [NUM_CH-1:0]      S_AXIS_TREADY,
   output logic [63:0]            M_AXIS_TDATA,
   output logic                   M_AXIS_TVALID,
   output logic                   M_AXIS_TLAST,
   output logic [7:0]             M_AXIS_TKEEP,
   output logic [31:0]            M_AXIS_TUSER,
   input  logic                   M_AXIS_TREADY,
   input  logic [31:0]            cmd,
   input  logic [NUM_CH-1:0]      ch_enable,
   input  logic [NUM_CH*16-1:0]   srio_streamID,
   input  logic [NUM_CH*16-1:0]   srio_length,
   input  logic [NUM_CH*8-1:0]    srio_cos,
   input  logic [NUM_CH*32-1:0]   srcdest,
   output logic [2:0]             cur_ch,
   output logic [CNT_W-1:0]       pkt_cnt,
   output logic [CNT_W-1:0]       early_cnt
);

   typedef enum logic [1:0] {IDLE, ARB, HDR, PAYLOAD} state_t;

   state_t            r_state, w_nextState;
   logic [63:0]       r_bufData [NUM_CH];
   logic [NUM_CH-1:0] r_bufValid, r_bufLast;
   logic [2:0]        r_curCh, r_ptr;
   logic [15:0]       r_len, r_sid;
   logic [7:0]        r_cos;
   logic [31:0]       r_tuser;
   logic [13:0]       r_cnt;
   logic [CNT_W-1:0]  r_pktCnt, r_earlyCnt;

   logic              w_rst, w_hit, w_selValid, w_selLast, w_payHs, w_cntLast, w_lastBeat, w_pktDone;
   logic [2:0]        w_grant;
   logic [63:0]       w_selData;
   logic [13:0]       w_psize;
   logic [NUM_CH-1:0] w_elig, w_drain;
   logic              w_unusedCmd;

   assign w_rst       = AXIS_ARESET | cmd[1];
   assign w_unusedCmd = ^cmd[31:2];

   always_comb begin
      w_selValid = 1'b0;
      w_selLast  = 1'b0;
      w_selData  = '0;
      w_elig     = '0;
      w_drain    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_elig[i]  = ch_enable[i] & r_bufValid[i] & (srio_length[16*i +: 16] != 16'd0);
         w_drain[i] = (r_state == PAYLOAD) & (r_curCh == 3'(i)) & r_bufValid[i] & M_AXIS_TREADY;
         if (r_curCh == 3'(i)) begin
            w_selValid = r_bufValid[i];
            w_selLast  = r_bufLast[i];
            w_selData  = r_bufData[i];
         end
      end
   end

   // Rotating priority: first eligible at or above the pointer, then wrap to the low channels.
   always_comb begin
      w_hit   = 1'b0;
      w_grant = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!w_hit && i >= int'(r_ptr) && w_elig[i]) begin
            w_hit   = 1'b1;
            w_grant = 3'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!w_hit && i < int'(r_ptr) && w_elig[i]) begin
            w_hit   = 1'b1;
            w_grant = 3'(i);
         end
      end
   end

   assign w_psize    = {1'b0, r_len[15:3]} + {13'd0, |r_len[2:0]};
   assign w_cntLast  = (r_cnt + 14'd1) == w_psize;
   assign w_lastBeat = w_cntLast | w_selLast;
   assign w_payHs    = (r_state == PAYLOAD) & w_selValid & M_AXIS_TREADY;
   assign w_pktDone  = w_payHs & w_lastBeat;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         S_AXIS_TREADY[i] = ~w_rst & (~r_bufValid[i] | w_drain[i]);
      end
   end

   always_ff @(posedge AXIS_ACLK) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_rst) begin
            r_bufValid[i] <= 1'b0;
         end else if (S_AXIS_TVALID[i] && S_AXIS_TREADY[i]) begin
            r_bufData[i]  <= S_AXIS_TDATA[64*i +: 64];
            r_bufLast[i]  <= S_AXIS_TLAST[i];
            r_bufValid[i] <= 1'b1;
         end else if (w_drain[i]) begin
            r_bufValid[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge AXIS_ACLK) begin
      if (w_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (cmd[0]) w_nextState = ARB;
         ARB: begin
            if (!cmd[0])    w_nextState = IDLE;
            else if (w_hit) w_nextState = HDR;
         end
         HDR:     if (M_AXIS_TREADY) w_nextState = PAYLOAD;
         PAYLOAD: if (w_pktDone) w_nextState = cmd[0] ? ARB : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      M_AXIS_TVALID = 1'b0;
      M_AXIS_TDATA  = '0;
      M_AXIS_TLAST  = 1'b0;
      M_AXIS_TKEEP  = '0;
      case (r_state)
         HDR: begin
            M_AXIS_TVALID = 1'b1;
            M_AXIS_TDATA  = {8'h00, 4'b1001, 4'h0, 1'b0, PRIO, CRF, r_cos, 4'h0, r_sid, r_len};
            M_AXIS_TKEEP  = 8'hFF;
         end
         PAYLOAD: begin
            M_AXIS_TVALID = w_selValid;
            M_AXIS_TDATA  = w_selData;
            M_AXIS_TLAST  = w_selValid & w_lastBeat;
            M_AXIS_TKEEP  = (w_cntLast && r_len[2:0] != 3'd0) ?
                            (8'hFF << (4'd8 - {1'b0, r_len[2:0]})) : 8'hFF;
         end
         default: ;
      endcase
   end

   // Header fields and TUSER are frozen at grant so later config edits miss the packet in flight.
   always_ff @(posedge AXIS_ACLK) begin
      if (w_rst) begin
         r_curCh    <= '0;
         r_ptr      <= '0;
         r_len      <= '0;
         r_sid      <= '0;
         r_cos      <= '0;
         r_tuser    <= '0;
         r_cnt      <= '0;
         r_pktCnt   <= '0;
         r_earlyCnt <= '0;
      end else begin
         if (r_state == ARB && cmd[0] && w_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (w_grant == 3'(i)) begin
                  r_len   <= srio_length[16*i +: 16];
                  r_sid   <= srio_streamID[16*i +: 16];
                  r_cos   <= srio_cos[8*i +: 8];
                  r_tuser <= srcdest[32*i +: 32];
               end
            end
            r_curCh <= w_grant;
            r_ptr   <= (w_grant == 3'(NUM_CH - 1)) ? 3'd0 : w_grant + 3'd1;
         end
         if (r_state == HDR && M_AXIS_TREADY) begin
            r_cnt <= '0;
         end else if (w_payHs) begin
            r_cnt <= r_cnt + 14'd1;
         end
         if (w_pktDone) begin
            r_pktCnt <= r_pktCnt + 1'b1;
            if (w_selLast && !w_cntLast) begin
               r_earlyCnt <= r_earlyCnt + 1'b1;
            end
         end
      end
   end

   assign M_AXIS_TUSER = r_tuser;
   assign cur_ch       = r_curCh;
   assign pkt_cnt      = r_pktCnt;
   assign early_cnt    = r_earlyCnt;

endmodule

// File: tb/tb_srio_type9_pack_mux.sv
// Directed bench for srio_type9_pack_mux: two channels, queued sources, a beat monitor
// on the master side, and one task per scenario with hand-computed expectations.
module tb_srio_type9_pack_mux;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
      logic [7:0]  k;
      logic [31:0] u;
      logic [2:0]  c;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] sData;
   logic [1:0]   sValid, sLast, sReady;
   logic [63:0]  mData;
   logic         mValid, mLast, mReady;
   logic [7:0]   mKeep;
   logic [31:0]  mUser, cmd;
   logic [1:0]   chEn;
   logic [31:0]  sid, len;
   logic [15:0]  cos;
   logic [63:0]  srcd;
   logic [2:0]   curCh;
   logic [15:0]  pktCnt, earlyCnt;

   logic [64:0]  q0[$];
   logic [64:0]  q1[$];
   beat_t        obs[$];
   beat_t        prevBeat;
   logic [1:0]   accPrev = 2'b00;
   logic         prevStall = 1'b0;
   bit           toggleMode = 1'b0;
   int           bpCnt = 0;
   int           assertions = 0;
   int           failures = 0;

   localparam logic [31:0] USER0 = 32'hC0DE0000;
   localparam logic [31:0] USER1 = 32'hC0DE1111;

   always #5 clk = ~clk;

   srio_type9_pack_mux #(.NUM_CH(2), .PRIO(2'b10), .CRF(1'b1), .CNT_W(16)) dut (
      .AXIS_ACLK(clk), .AXIS_ARESET(rst),
      .S_AXIS_TDATA(sData), .S_AXIS_TVALID(sValid), .S_AXIS_TLAST(sLast), .S_AXIS_TREADY(sReady),
      .M_AXIS_TDATA(mData), .M_AXIS_TVALID(mValid), .M_AXIS_TLAST(mLast), .M_AXIS_TKEEP(mKeep),
      .M_AXIS_TUSER(mUser), .M_AXIS_TREADY(mReady),
      .cmd(cmd), .ch_enable(chEn), .srio_streamID(sid), .srio_length(len), .srio_cos(cos),
      .srcdest(srcd), .cur_ch(curCh), .pkt_cnt(pktCnt), .early_cnt(earlyCnt)
   );

   // Sources pop a beat one cycle after it was accepted and present the next queued one.
   initial begin
      sValid = '0; sLast = '0; sData = '0; mReady = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (accPrev[0] && q0.size() > 0) void'(q0.pop_front());
         if (accPrev[1] && q1.size() > 0) void'(q1.pop_front());
         if (q0.size() > 0) begin sValid[0] = 1'b1; sLast[0] = q0[0][64]; sData[63:0] = q0[0][63:0]; end
         else sValid[0] = 1'b0;
         if (q1.size() > 0) begin sValid[1] = 1'b1; sLast[1] = q1[0][64]; sData[127:64] = q1[0][63:0]; end
         else sValid[1] = 1'b0;
         mReady = toggleMode ? ~mReady : 1'b1;
      end
   end

   // Master monitor: records handshaken beats and checks stall stability.
   initial begin
      forever begin
         @(negedge clk);
         accPrev = sValid & sReady;
         if (prevStall && mValid) begin
            assertions++;
            if ({mData, mLast, mKeep} !== {prevBeat.d, prevBeat.l, prevBeat.k}) begin
               failures++;
               $display("[TB] FAIL stall_stable actual=%h/%b/%h required=%h/%b/%h",
                        mData, mLast, mKeep, prevBeat.d, prevBeat.l, prevBeat.k);
            end
         end
         prevStall = mValid & ~mReady;
         prevBeat  = '{d: mData, l: mLast, k: mKeep, u: mUser, c: curCh};
         if (mValid && mReady) obs.push_back('{d: mData, l: mLast, k: mKeep, u: mUser, c: curCh});
         if (sValid[0] && !sReady[0] && !rst && !cmd[1]) bpCnt++;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitBeats(input int k, output bit ok);
      int n = 0;
      while (obs.size() < k && n < 3000) begin
         @(negedge clk); #1;
         n++;
      end
      repeat (6) begin @(negedge clk); #1; end
      ok = (obs.size() == k);
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd = '0; chEn = 2'b11;
      sid = {16'hBEEF, 16'h1234}; len = {16'd16, 16'd16};
      cos = {8'h3C, 8'h5A}; srcd = {USER1, USER0};
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk); #1;
      assertions++; if (mValid !== 1'b0)    begin failures++; $display("[TB] FAIL rst_tvalid actual=%b required=0", mValid); end
      assertions++; if (mLast !== 1'b0)     begin failures++; $display("[TB] FAIL rst_tlast actual=%b required=0", mLast); end
      assertions++; if (mKeep !== 8'h00)    begin failures++; $display("[TB] FAIL rst_tkeep actual=%h required=00", mKeep); end
      assertions++; if (mUser !== 32'h0)    begin failures++; $display("[TB] FAIL rst_tuser actual=%h required=0", mUser); end
      assertions++; if (curCh !== 3'd0)     begin failures++; $display("[TB] FAIL rst_cur_ch actual=%0d required=0", curCh); end
      assertions++; if (pktCnt !== 16'd0)   begin failures++; $display("[TB] FAIL rst_pkt_cnt actual=%0d required=0", pktCnt); end
      assertions++; if (earlyCnt !== 16'd0) begin failures++; $display("[TB] FAIL rst_early_cnt actual=%0d required=0", earlyCnt); end
      assertions++; if (sReady !== 2'b11)   begin failures++; $display("[TB] FAIL rst_s_tready actual=%b required=11", sReady); end
      @(posedge clk); #2 cmd = 32'h1;
   endtask

   task automatic test_round_robin();
      logic [63:0] expD [12];
      logic        expL [12];
      logic [2:0]  expC [12];
      bit ok;
      expD = '{64'h009055A0_12340010, 64'hA0A0_0000_0000_0000, 64'hA0A0_0000_0000_0001,
               64'h009053C0_BEEF0010, 64'hB0B0_0000_0000_0000, 64'hB0B0_0000_0000_0001,
               64'h009055A0_12340010, 64'hA0A0_0000_0000_0002, 64'hA0A0_0000_0000_0003,
               64'h009053C0_BEEF0010, 64'hB0B0_0000_0000_0002, 64'hB0B0_0000_0000_0003};
      expL = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
      expC = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
      obs.delete();
      for (int i = 0; i < 4; i++) begin
         q0.push_back({1'b0, 64'hA0A0_0000_0000_0000 | 64'(i)});
         q1.push_back({1'b0, 64'hB0B0_0000_0000_0000 | 64'(i)});
      end
      waitBeats(12, ok);
      assertions++;
      if (!ok) begin
         failures++; $display("[TB] FAIL rr_beat_count actual=%0d required=12", obs.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            assertions++; if (obs[i].d !== expD[i]) begin failures++; $display("[TB] FAIL rr_data[%0d] actual=%h required=%h", i, obs[i].d, expD[i]); end
            assertions++; if (obs[i].l !== expL[i]) begin failures++; $display("[TB] FAIL rr_last[%0d] actual=%b required=%b", i, obs[i].l, expL[i]); end
            assertions++; if (obs[i].c !== expC[i]) begin failures++; $display("[TB] FAIL rr_cur_ch[%0d] actual=%0d required=%0d", i, obs[i].c, expC[i]); end
            assertions++; if (obs[i].u !== ((expC[i] == 3'd0) ? USER0 : USER1)) begin
               failures++; $display("[TB] FAIL rr_tuser[%0d] actual=%h required=%h", i, obs[i].u, (expC[i] == 3'd0) ? USER0 : USER1);
            end
         end
      end
      assertions++; if (pktCnt !== 16'd4) begin failures++; $display("[TB] FAIL rr_pkt_cnt actual=%0d required=4", pktCnt); end
   endtask

   task automatic test_basic();
      logic [63:0] expD [4];
      bit ok;
      expD = '{64'h009055A0_12340018, 64'h1111_AAAA_0000_000A, 64'h2222_BBBB_0000_000B, 64'h3333_CCCC_0000_000C};
      obs.delete();
      len[15:0] = 16'd24;
      q0.push_back({1'b0, expD[1]}); q0.push_back({1'b0, expD[2]}); q0.push_back({1'b0, expD[3]});
      waitBeats(4, ok);
      assertions++;
      if (!ok) begin
         failures++; $display("[TB] FAIL basic_beat_count actual=%0d required=4", obs.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            assertions++; if (obs[i].d !== expD[i]) begin failures++; $display("[TB] FAIL basic_data[%0d] actual=%h required=%h", i, obs[i].d, expD[i]); end
            assertions++; if (obs[i].l !== (i == 3)) begin failures++; $display("[TB] FAIL basic_last[%0d] actual=%b required=%b", i, obs[i].l, i == 3); end
            assertions++; if (obs[i].k !== 8'hFF) begin failures++; $display("[TB] FAIL basic_keep[%0d] actual=%h required=FF", i, obs[i].k); end
         end
      end
      assertions++; if (pktCnt !== 16'd5) begin failures++; $display("[TB] FAIL basic_pkt_cnt actual=%0d required=5", pktCnt); end
   endtask

   task automatic test_partial_keep();
      logic [63:0] expD [4];
      logic [7:0]  expK [4];
      bit ok;
      expD = '{64'h009055A0_12340014, 64'hD000_0000_0000_0001, 64'hD000_0000_0000_0002, 64'hD000_0000_0000_0003};
      expK = '{8'hFF, 8'hFF, 8'hFF, 8'hF0};
      obs.delete();
      len[15:0] = 16'd20;
      q0.push_back({1'b0, expD[1]}); q0.push_back({1'b0, expD[2]}); q0.push_back({1'b0, expD[3]});
      waitBeats(4, ok);
      assertions++;
      if (!ok) begin
         failures++; $display("[TB] FAIL partial_beat_count actual=%0d required=4", obs.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            assertions++; if (obs[i].d !== expD[i]) begin failures++; $display("[TB] FAIL partial_data[%0d] actual=%h required=%h", i, obs[i].d, expD[i]); end
            assertions++; if (obs[i].l !== (i == 3)) begin failures++; $display("[TB] FAIL partial_last[%0d] actual=%b required=%b", i, obs[i].l, i == 3); end
            assertions++; if (obs[i].k !== expK[i]) begin failures++; $display("[TB] FAIL partial_keep[%0d] actual=%h required=%h", i, obs[i].k, expK[i]); end
         end
      end
      assertions++; if (pktCnt !== 16'd6) begin failures++; $display("[TB] FAIL partial_pkt_cnt actual=%0d required=6", pktCnt); end
   endtask

   task automatic test_early_tlast();
      logic [63:0] expD [6];
      logic        expL [6];
      bit ok;
      expD = '{64'h009053C0_BEEF0040, 64'hE000_0000_0000_0000, 64'hE000_0000_0000_0001,
               64'hE000_0000_0000_0002, 64'h009053C0_BEEF0040, 64'hE000_0000_0000_0003};
      expL = '{0, 0, 0, 1, 0, 1};
      obs.delete();
      len[31:16] = 16'd64;
      q1.push_back({1'b0, expD[1]}); q1.push_back({1'b0, expD[2]});
      q1.push_back({1'b1, expD[3]}); q1.push_back({1'b1, expD[5]});
      waitBeats(6, ok);
      assertions++;
      if (!ok) begin
         failures++; $display("[TB] FAIL early_beat_count actual=%0d required=6", obs.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            assertions++; if (obs[i].d !== expD[i]) begin failures++; $display("[TB] FAIL early_data[%0d] actual=%h required=%h", i, obs[i].d, expD[i]); end
            assertions++; if (obs[i].l !== expL[i]) begin failures++; $display("[TB] FAIL early_last[%0d] actual=%b required=%b", i, obs[i].l, expL[i]); end
            assertions++; if (obs[i].k !== 8'hFF) begin failures++; $display("[TB] FAIL early_keep[%0d] actual=%h required=FF", i, obs[i].k); end
            assertions++; if (obs[i].c !== 3'd1) begin failures++; $display("[TB] FAIL early_cur_ch[%0d] actual=%0d required=1", i, obs[i].c); end
         end
      end
      assertions++; if (earlyCnt !== 16'd2) begin failures++; $display("[TB] FAIL early_cnt actual=%0d required=2", earlyCnt); end
      assertions++; if (pktCnt !== 16'd8) begin failures++; $display("[TB] FAIL early_pkt_cnt actual=%0d required=8", pktCnt); end
   endtask

   task automatic test_back_to_back_stall();
      logic [63:0] expD [5];
      bit ok;
      expD = '{64'h009055A0_12340020, 64'h5000_0000_0000_0000, 64'h5000_0000_0000_0001,
               64'h5000_0000_0000_0002, 64'h5000_0000_0000_0003};
      obs.delete();
      bpCnt = 0;
      len[15:0] = 16'd32;
      toggleMode = 1'b1;
      for (int i = 1; i < 5; i++) q0.push_back({1'b0, expD[i]});
      waitBeats(5, ok);
      toggleMode = 1'b0;
      assertions++;
      if (!ok) begin
         failures++; $display("[TB] FAIL stall_beat_count actual=%0d required=5", obs.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            assertions++; if (obs[i].d !== expD[i]) begin failures++; $display("[TB] FAIL stall_data[%0d] actual=%h required=%h", i, obs[i].d, expD[i]); end
            assertions++; if (obs[i].l !== (i == 4)) begin failures++; $display("[TB] FAIL stall_last[%0d] actual=%b required=%b", i, obs[i].l, i == 4); end
         end
      end
      assertions++; if (bpCnt == 0) begin failures++; $display("[TB] FAIL stall_backpressure actual=0 required=nonzero"); end
      assertions++; if (pktCnt !== 16'd9) begin failures++; $display("[TB] FAIL stall_pkt_cnt actual=%0d required=9", pktCnt); end
   endtask

   task automatic test_soft_reset();
      logic [63:0] expD [3];
      int n = 0;
      bit ok;
      expD = '{64'h009055A0_12340010, 64'h7000_0000_0000_00A0, 64'h7000_0000_0000_00A1};
      obs.delete();
      len[15:0] = 16'd64;
      for (int i = 0; i < 8; i++) q0.push_back({1'b0, 64'h6000_0000_0000_0000 | 64'(i)});
      while (obs.size() < 3 && n < 3000) begin @(negedge clk); #1; n++; end
      assertions++; if (obs.size() < 3) begin failures++; $display("[TB] FAIL sreset_pre_beats actual=%0d required=3", obs.size()); end
      @(posedge clk); #2 cmd = 32'h3;
      q0.delete();
      @(posedge clk); #2 cmd = 32'h1;
      @(negedge clk); #1;
      assertions++; if (mValid !== 1'b0)    begin failures++; $display("[TB] FAIL sreset_tvalid actual=%b required=0", mValid); end
      assertions++; if (mLast !== 1'b0)     begin failures++; $display("[TB] FAIL sreset_tlast actual=%b required=0", mLast); end
      assertions++; if (sReady !== 2'b11)   begin failures++; $display("[TB] FAIL sreset_s_tready actual=%b required=11", sReady); end
      assertions++; if (pktCnt !== 16'd0)   begin failures++; $display("[TB] FAIL sreset_pkt_cnt actual=%0d required=0", pktCnt); end
      assertions++; if (earlyCnt !== 16'd0) begin failures++; $display("[TB] FAIL sreset_early_cnt actual=%0d required=0", earlyCnt); end
      assertions++; if (mUser !== 32'h0)    begin failures++; $display("[TB] FAIL sreset_tuser actual=%h required=0", mUser); end
      obs.delete();
      len[15:0] = 16'd16;
      q0.push_back({1'b0, expD[1]}); q0.push_back({1'b0, expD[2]});
      waitBeats(3, ok);
      assertions++;
      if (!ok) begin
         failures++; $display("[TB] FAIL sreset_beat_count actual=%0d required=3", obs.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            assertions++; if (obs[i].d !== expD[i]) begin failures++; $display("[TB] FAIL sreset_data[%0d] actual=%h required=%h", i, obs[i].d, expD[i]); end
            assertions++; if (obs[i].l !== (i == 2)) begin failures++; $display("[TB] FAIL sreset_last[%0d] actual=%b required=%b", i, obs[i].l, i == 2); end
         end
      end
      assertions++; if (pktCnt !== 16'd1) begin failures++; $display("[TB] FAIL sreset_pkt_cnt_after actual=%0d required=1", pktCnt); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_basic();
      test_partial_keep();
      test_early_tlast();
      test_back_to_back_stall();
      test_soft_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/srio_type9_pack_mux.md
Name: srio_type9_pack_mux

Overview:
N-channel SRIO Type 9 (data streaming) packetiser. Each channel takes a 64-bit AXIS payload stream plus its own stream ID, length, COS and src/dest. A round-robin arbiter picks one channel per packet. The block emits the 64-bit Type 9 header beat followed by that channel's payload beats on a single AXIS master toward the SRIO user port. It extends the single-channel packer with channel muxing, byte-accurate TKEEP on the last beat, config latching at grant, and status counters.

Parameters:
NUM_CH, 2, number of input channels (1..8)
PRIO, 2'b00, header priority field
CRF, 1'b0, header critical-request-flow bit
CNT_W, 16, width of the status counters

Ports:
AXIS_ACLK  in  1  clock
AXIS_ARESET  in  1  synchronous active-high reset
S_AXIS_TDATA  in  NUM_CH*64  channel payload, ch i at [64i+63:64i]
S_AXIS_TVALID  in  NUM_CH  per-channel valid
S_AXIS_TLAST  in  NUM_CH  per-channel early end of payload
S_AXIS_TREADY  out  NUM_CH  per-channel ready
M_AXIS_TDATA  out  64  header/payload beat
M_AXIS_TVALID  out  1  master valid
M_AXIS_TLAST  out  1  last beat of packet
M_AXIS_TKEEP  out  8  byte enables, byte 0 = [63:56]
M_AXIS_TUSER  out  32  latched srcdest of the granted channel
M_AXIS_TREADY  in  1  master ready
cmd  in  32  bit0 start (level run enable), bit1 soft reset
ch_enable  in  NUM_CH  per-channel arbitration enable
srio_streamID  in  NUM_CH*16  per-channel stream ID
srio_length  in  NUM_CH*16  per-channel PDU length in bytes
srio_cos  in  NUM_CH*8  per-channel class of service
srcdest  in  NUM_CH*32  per-channel TUSER value
cur_ch  out  3  channel currently granted
pkt_cnt  out  CNT_W  packets completed, wraps
early_cnt  out  CNT_W  packets ended by S_AXIS_TLAST before the length was reached, wraps

Behaviour:
- Reset (AXIS_ARESET or cmd[1]): all outputs 0, so TVALID=0, TLAST=0, TKEEP=0, TUSER=0, cur_ch=0, both counters 0; all skid buffers empty; RR pointer=0; state IDLE. cmd[1] mid-packet aborts it: TVALID=0 on the next cycle and no TLAST is emitted.
- Per-channel input skid: one 64-bit data + tlast register with a valid flag.
  - TREADY[i] = buffer empty OR (buffer drained this cycle by the master).
  - Capture on TVALID&TREADY.
  - Drain only while channel i is granted and in PAYLOAD with an M handshake.
- payload_size = ceil(len/8) = len[15:3] + (len[2:0]!=0), 14-bit. A channel with len==0 is ineligible.
- States:
  - IDLE: if cmd[0] go to ARB.
  - ARB (1 cycle): eligible = ch_enable & buffer_valid & len!=0. Search starts at the RR pointer, upward with wrap. On a hit:
    - latch header fields and srcdest;
    - set cur_ch; pointer = grant+1 mod NUM_CH;
    - go to HDR.
    - With no hit, stay in ARB. Go to IDLE if cmd[0]=0.
  - HDR: TVALID=1. TDATA = {8'h0, 4'b1001, 4'h0, 1'b0, PRIO, CRF, cos, 4'h0, streamID, length} from the latched fields. TKEEP=8'hFF, TLAST=0. On handshake, go to PAYLOAD and clear the beat count to 0.
  - PAYLOAD: TVALID = granted buffer valid, TDATA = buffer data. Last beat = (cnt+1==payload_size) OR buffer tlast.
    - TLAST = last beat.
    - TKEEP on the final length beat with len[2:0]=k!=0: top k bytes set (8'hFF<<(8-k)). Otherwise 8'hFF.
    - On handshake: cnt++. If last beat: pkt_cnt++; early_cnt++ if ended by tlast and not by count; go to ARB if cmd[0], else IDLE.
- Beats beyond payload_size are never merged: an input tlast arriving later only closes a following packet.
- cmd[0] dropping mid-packet: the current packet completes, then IDLE.
- Config or ch_enable changes after grant do not affect the packet in flight.
- TDATA/TKEEP/TLAST are stable while TVALID=1 and TREADY=0.
- Minimum packet spacing: 1 ARB cycle between TLAST and the next header.

Test Plan:
1. NUM_CH=2, ch0 len=24, 3 beats A,B,C, TREADY=1 → header (type nibble 9, len 0x0018), then A, B, C. TLAST on C, TKEEP all 8'hFF, pkt_cnt=1.
2. ch0 len=20 → 3 payload beats; last beat TKEEP=8'hF0, TLAST=1.
3. Both channels continuously valid, len=16 → grant order 0,1,0,1, cur_ch alternates, TUSER follows each channel's srcdest.
4. ch1 len=64 with S_AXIS_TLAST on beat 3 → M TLAST on beat 3, TKEEP=8'hFF, early_cnt=1, next header follows.
5. M_AXIS_TREADY toggling 1010… during payload → no beat lost or duplicated, data stable across stalls, S_AXIS_TREADY backpressures.
6. cmd[1] pulsed mid-payload → TVALID=0 next cycle, skids empty, state IDLE; with cmd[0] held, the next packet restarts cleanly with a header.
